// File: rtl/mem_stage.sv
`default_nettype none
// mem_stage: memory-access pipeline stage with req/ack data memory, wait states and access timeout.
// Optional macro MEM_STAGE_ALIGN_CHECK_EN rejects misaligned loads/stores with mem_err instead of issuing them.
module mem_stage #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_valid,
  input  logic [31:0] ex_result,
  input  logic [31:0] ex_store_data,
  input  logic        ex_mem_rd,
  input  logic        ex_mem_wr,
  input  logic        ex_wb_en,
  input  logic [4:0]  ex_wb_reg,
  output logic        stall,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        wb_valid,
  output logic        wb_en,
  output logic [4:0]  wb_reg,
  output logic [31:0] wb_data,
  output logic        mem_err
);

  typedef enum logic [0:0] {
    S_IDLE   = 1'b0,
    S_ACCESS = 1'b1
  } state_t;

  // r_cnt holds the number of request cycles already completed, so the
  // last permitted cycle is the one where it equals TIMEOUT_CYCLES-1.
  localparam logic [7:0] c_TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t      r_state;
  state_t      w_state_next;
  logic [7:0]  r_cnt;
  logic        r_we;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic        r_cap_en;
  logic [4:0]  r_cap_reg;
  logic        r_wb_valid;
  logic        r_wb_en;
  logic [4:0]  r_wb_reg;
  logic [31:0] r_wb_data;
  logic        r_mem_err;

  logic w_mem_op;
  logic w_misalign;
  logic w_issue;
  logic w_pass;
  logic w_done;
  logic w_timeout;
  logic w_align_err;

  assign w_mem_op = ex_mem_rd | ex_mem_wr;

`ifdef MEM_STAGE_ALIGN_CHECK_EN
  assign w_misalign = (ex_result[1:0] != 2'b00);
`else
  logic w_unused_lo;
  assign w_misalign  = 1'b0;
  assign w_unused_lo = ^ex_result[1:0];
`endif

  always_comb begin
    w_state_next = r_state;
    w_issue      = 1'b0;
    w_pass       = 1'b0;
    w_done       = 1'b0;
    w_timeout    = 1'b0;
    w_align_err  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (ex_valid) begin
          if (!w_mem_op) begin
            w_pass = 1'b1;
          end else if (w_misalign) begin
            w_align_err = 1'b1;
          end else begin
            w_issue      = 1'b1;
            w_state_next = S_ACCESS;
          end
        end
      end
      S_ACCESS: begin
        // An ack on the final permitted cycle takes precedence over timeout.
        if (dmem_ack) begin
          w_done       = 1'b1;
          w_state_next = S_IDLE;
        end else if (r_cnt == c_TMO_LAST) begin
          w_timeout    = 1'b1;
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt      <= 8'd0;
      r_we       <= 1'b0;
      r_addr     <= 32'd0;
      r_wdata    <= 32'd0;
      r_cap_en   <= 1'b0;
      r_cap_reg  <= 5'd0;
      r_wb_valid <= 1'b0;
      r_wb_en    <= 1'b0;
      r_wb_reg   <= 5'd0;
      r_wb_data  <= 32'd0;
      r_mem_err  <= 1'b0;
    end else begin
      if (w_issue) begin
        r_cnt     <= 8'd0;
        r_we      <= ex_mem_wr;
        r_addr    <= {ex_result[31:2], 2'b00};
        r_wdata   <= ex_store_data;
        r_cap_en  <= ex_wb_en;
        r_cap_reg <= ex_wb_reg;
      end else if (r_state == S_ACCESS) begin
        r_cnt <= r_cnt + 8'd1;
      end

      r_wb_valid <= w_pass | w_done;
      r_mem_err  <= w_timeout | w_align_err;

      if (w_pass) begin
        r_wb_en   <= ex_wb_en;
        r_wb_reg  <= ex_wb_reg;
        r_wb_data <= ex_result;
      end else if (w_done) begin
        r_wb_reg <= r_cap_reg;
        if (r_we) begin
          r_wb_en   <= 1'b0;
          r_wb_data <= 32'd0;
        end else begin
          r_wb_en   <= r_cap_en;
          r_wb_data <= dmem_rdata;
        end
      end
    end
  end

  assign stall      = (r_state == S_ACCESS);
  assign dmem_req   = (r_state == S_ACCESS);
  assign dmem_we    = r_we;
  assign dmem_addr  = r_addr;
  assign dmem_wdata = r_wdata;
  assign wb_valid   = r_wb_valid;
  assign wb_en      = r_wb_en;
  assign wb_reg     = r_wb_reg;
  assign wb_data    = r_wb_data;
  assign mem_err    = r_mem_err;

endmodule
`default_nettype wire

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access pipeline stage directly downstream of the execute stage.
- Consumes the execute result (ALU result or effective address) and the forwarded store data.
- Performs word loads/stores over a req/ack data-memory interface with variable wait states, stalling upstream while an access is outstanding.
- Presents a registered result to writeback.

Parameters:
- TIMEOUT_CYCLES, 16: maximum cycles dmem_req may stay asserted without dmem_ack before the access is aborted; legal range 1..255.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- ex_valid  input  1  execute-stage output valid this cycle
- ex_result  input  32  execute result; the memory address for loads and stores
- ex_store_data  input  32  store data (register operand 1 passed through execute)
- ex_mem_rd  input  1  instruction is a load
- ex_mem_wr  input  1  instruction is a store
- ex_wb_en  input  1  instruction writes a register
- ex_wb_reg  input  5  destination register index
- stall  output  1  upstream must hold its current instruction
- dmem_req  output  1  data-memory request
- dmem_we  output  1  1 = write, 0 = read
- dmem_addr  output  32  word address
- dmem_wdata  output  32  write data
- dmem_rdata  input  32  read data, valid when dmem_ack=1
- dmem_ack  input  1  access complete, single-cycle pulse
- wb_valid  output  1  writeback bundle valid, one-cycle pulse per instruction
- wb_en  output  1  register write enable
- wb_reg  output  5  destination register
- wb_data  output  32  load data or pass-through ALU result
- mem_err  output  1  one-cycle pulse on access timeout

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE; timeout counter cleared.
  - All outputs 0 immediately: stall, dmem_req, dmem_we, dmem_addr, dmem_wdata, wb_*, mem_err.
  - Reset during ACCESS drops dmem_req without waiting for ack. A late ack after reset release is ignored in IDLE.
- States: IDLE, ACCESS.
- IDLE, ex_valid=1, no memory op:
  - Registered pass-through: next cycle wb_valid=1, wb_data=ex_result, wb_en=ex_wb_en, wb_reg=ex_wb_reg.
  - Latency 1 cycle; back-to-back accepted every cycle.
- IDLE, ex_valid=1 with ex_mem_rd or ex_mem_wr:
  - Capture ex_result, ex_store_data, ex_wb_reg and the op type; go to ACCESS.
  - From the next cycle: dmem_req=1, dmem_we=ex_mem_wr, dmem_addr=ex_result, dmem_wdata=ex_store_data.
  - Address, data and we are held stable until ack.
  - If both rd and wr are set, wr takes priority; the op is a store.
- ACCESS:
  - stall=1 (stall is decoded from state only, no combinational path from dmem_ack). ex_* inputs are ignored.
  - The counter increments each cycle dmem_req is high.
  - On dmem_ack=1:
    - Next cycle: dmem_req=0, state IDLE, stall=0.
    - Same next cycle: wb_valid=1.
    - Load: wb_data = dmem_rdata sampled on the ack cycle, wb_en = captured ex_wb_en.
    - Store: wb_en=0, wb_data=0.
  - If ack arrives on the first request cycle, the total load latency is 2 cycles from ex_valid to wb_valid.
- Timeout:
  - Triggered when the counter reaches TIMEOUT_CYCLES with no ack.
  - Next cycle: dmem_req=0, mem_err=1 for one cycle, wb_valid=0, state IDLE.
  - The aborted instruction produces no writeback.
  - An ack on the same cycle the timeout is reached wins: normal completion, no mem_err.
- Upstream protocol: when stall=1, upstream holds the same instruction and ex_valid. That instruction is accepted on the first cycle stall=0.
- wb_valid, wb_en, wb_reg, wb_data are registered. wb_valid is 0 on any cycle without a completing instruction; wb_data holds its last value.

Optional Feature:
- Macro: MEM_STAGE_ALIGN_CHECK_EN
- Defined:
  - A memory op with ex_result[1:0] != 0 is not issued; state stays IDLE, no dmem_req.
  - Next cycle: mem_err=1 for one cycle, wb_valid=0.
- Undefined:
  - No check; dmem_addr = {ex_result[31:2], 2'b00} for all accesses.
  - No error is raised for low address bits.

Test Plan:
- Reset: assert rst_n=0 mid-ACCESS with dmem_req=1 -> dmem_req, stall, wb_valid go 0 without a clock edge; after release, state IDLE and a stray dmem_ack=1 produces no wb_valid.
- ALU pass-through: ex_valid=1, ex_result=0x0000_1234, wb_en=1, reg=5, three back-to-back instructions -> wb_valid=1 on each following cycle with wb_data=0x1234, wb_reg=5; stall stays 0.
- Load with wait: load addr 0x100, dmem_ack after 3 req cycles with rdata=0xDEAD_BEEF -> stall=1 for 3 cycles, dmem_addr stable at 0x100, wb_data=0xDEADBEEF one cycle after ack.
- Store, zero-wait: store addr 0x200, data 0xCAFE_0001, ack on the first req cycle -> dmem_we=1, dmem_wdata=0xCAFE0001, wb_valid=1 with wb_en=0; next instruction accepted the following cycle.
- Timeout: TIMEOUT_CYCLES=4, no ack -> dmem_req high exactly 4 cycles, then mem_err pulse of 1 cycle, no wb_valid; a second run with ack on the 4th cycle -> normal completion, mem_err=0.
- Alignment (macro defined): load addr 0x102 -> no dmem_req, mem_err=1 next cycle. Macro undefined: same load -> dmem_addr=0x100.
